fqmul_mont_pipe: RTL

//  Pipelined, multi-lane Montgomery multiplier: r = a*b*R^-1 mod Q, R = 2^W.

---
 rtl/dilithium_pkg.sv | 20 ++
 rtl/fqmul_mont_pipe_if.sv | 36 +++
 rtl/fqmul_mont_lane.sv | 78 +++++++
 rtl/fqmul_mont_pipe.sv | 74 +++++++
 4 files changed

// File: rtl/dilithium_pkg.sv
// Shared constants and types for the Dilithium arithmetic datapaths.
// Holds the default coefficient width, the modulus, the Montgomery constants
// and the latency of the pipelined Montgomery multiplier. That latency depends
// on the optional macro FQMUL_CANON_EN.
package dilithium_pkg;

    localparam int unsigned DIL_W    = 32;
    localparam int unsigned DIL_Q    = 8380417;
    localparam int unsigned DIL_QINV = 58728449;  // Q^-1 mod 2^32
    localparam int unsigned DIL_MONT = 4193792;   // 2^32 mod Q

    typedef logic signed [DIL_W-1:0] coeff_t;

`ifdef FQMUL_CANON_EN
    localparam int unsigned DIL_FQMUL_LAT = 4;
`else
    localparam int unsigned DIL_FQMUL_LAT = 3;
`endif

endpackage

// File: rtl/fqmul_mont_pipe_if.sv
// Operand/result stream interface for fqmul_mont_pipe.
// Signals:
//   clear      synchronous flush of every pipeline stage
//   in_valid   operand beat valid         in_ready   beat accepted this cycle
//   a, b       LANES x W signed operands  (lane i = [i*W +: W])
//   out_valid  result beat valid          out_ready  downstream accepts result
//   r          LANES x W signed results   busy       a stage holds a valid beat
// The master modport is the producer/consumer side; the slave modport is the multiplier.
interface fqmul_mont_pipe_if
    import dilithium_pkg::*;
#(
    parameter int unsigned W     = DIL_W,
    parameter int unsigned LANES = 1
);

    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*W-1:0]   a;
    logic [LANES*W-1:0]   b;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*W-1:0]   r;
    logic                 busy;

    modport master (
        output clear, in_valid, a, b, out_ready,
        input  in_ready, out_valid, r, busy
    );

    modport slave (
        input  clear, in_valid, a, b, out_ready,
        output in_ready, out_valid, r, busy
    );

endinterface

// File: rtl/fqmul_mont_lane.sv
// One lane of the Montgomery multiplier datapath: r = a*b*2^-W mod Q.
// Every stage register loads when i_en is high. There is no valid tracking here.
// Ports:
//   i_clock, i_reset  clock, asynchronous active-high reset (data regs cleared)
//   i_en              pipeline advance
//   i_a, i_b          signed W-bit operands
//   o_r               signed W-bit result. It is canonical [0,Q) when FQMUL_CANON_EN is defined.
module fqmul_mont_lane
    import dilithium_pkg::*;
#(
    parameter int unsigned W    = DIL_W,
    parameter int unsigned Q    = DIL_Q,
    parameter int unsigned QINV = DIL_QINV
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_en,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_r
);

    localparam int unsigned W2     = 2 * W;
    localparam logic [W-1:0]  QINV_W = W'(QINV);
    localparam logic [W2-1:0] Q_W2   = W2'(Q);

    logic [W2-1:0] w_p;
    logic [W2-1:0] r_p1;
    logic [W2-1:0] r_p2;
    logic [W-1:0]  w_t;
    logic [W-1:0]  r_t;
    logic [W2-1:0] w_tq;
    logic [W2-1:0] w_d;
    logic [W-1:0]  r_r;
    logic          w_unused_lo;

    // Sign-extended operands make the low 2W bits of the product equal the signed product.
    assign w_p  = {{W{i_a[W-1]}}, i_a} * {{W{i_b[W-1]}}, i_b};
    assign w_t  = r_p1[W-1:0] * QINV_W;
    assign w_tq = {{W{r_t[W-1]}}, r_t} * Q_W2;
    assign w_d  = r_p2 - w_tq;
    // The subtraction cancels the low half exactly, so only the high half is kept.
    assign w_unused_lo = ^w_d[W-1:0];

    // S1 product, S2 Montgomery quotient, S3 reduction
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_p1 <= '0;
            r_p2 <= '0;
            r_t  <= '0;
            r_r  <= '0;
        end else if (i_en) begin
            r_p1 <= w_p;
            r_p2 <= r_p1;
            r_t  <= w_t;
            r_r  <= w_d[W2-1:W];
        end
    end

`ifdef FQMUL_CANON_EN
    localparam logic [W-1:0] Q_W = W'(Q);
    logic [W-1:0] r_c;

    // S4: fold the centred result into [0, Q)
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_c <= '0;
        end else if (i_en) begin
            r_c <= r_r + (r_r[W-1] ? Q_W : '0);
        end
    end

    assign o_r = r_c;
`else
    assign o_r = r_r;
`endif

endmodule

// File: rtl/fqmul_mont_pipe.sv
// Pipelined multi-lane Montgomery multiplier, r = a*b*2^-W mod Q.
// The multiplier takes one operand beat per cycle and uses valid/ready backpressure.
// Latency is 3 cycles, or 4 when FQMUL_CANON_EN is defined. The 4-cycle build
// gives a canonical output in [0, Q).
// Ports:
//   i_clock  rising-edge clock
//   i_reset  asynchronous active-high reset
//   bus      fqmul_mont_pipe_if slave: clear, in_valid/in_ready, a, b,
//            out_valid/out_ready, r, busy
module fqmul_mont_pipe
    import dilithium_pkg::*;
#(
    parameter int unsigned W     = DIL_W,
    parameter int unsigned LANES = 1,
    parameter int unsigned Q     = DIL_Q,
    parameter int unsigned QINV  = DIL_QINV
) (
    input  logic               i_clock,
    input  logic               i_reset,
    fqmul_mont_pipe_if.slave   bus
);

    localparam int unsigned STAGES = DIL_FQMUL_LAT;

    logic [STAGES-1:0]  r_vld;
    logic [STAGES-1:0]  w_vld_nxt;
    logic               r_busy;
    logic               w_adv;
    logic [LANES*W-1:0] w_r;

    // The whole pipe shifts when the output slot is empty or being drained.
    // clear wins over an incoming beat.
    always_comb begin
        w_adv     = !r_vld[STAGES-1] || bus.out_ready;
        w_vld_nxt = r_vld;
        if (bus.clear) begin
            w_vld_nxt = '0;
        end else if (w_adv) begin
            w_vld_nxt = {r_vld[STAGES-2:0], bus.in_valid};
        end
    end

    // Valid chain and busy flag
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_vld  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_vld  <= w_vld_nxt;
            r_busy <= |w_vld_nxt;
        end
    end

    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        fqmul_mont_lane #(
            .W    (W),
            .Q    (Q),
            .QINV (QINV)
        ) u_lane (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_en    (w_adv),
            .i_a     (bus.a[g*W +: W]),
            .i_b     (bus.b[g*W +: W]),
            .o_r     (w_r[g*W +: W])
        );
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_vld[STAGES-1];
    assign bus.r         = w_r;
    assign bus.busy      = r_busy;

endmodule
